// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one shift-and-correct iteration per clock with a start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [WORK_W-1:0]   work_reg, work_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [BIN_W-1:0]    bin_reg, bin_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  logic [DIGITS-1:0]   digit_bad;
  logic [WORK_W-1:0]   shifted;
  logic [WORK_W-1:0]   corrected;
  logic                last_iter;

  // Operand validation: any nibble above 9 rejects the whole request.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
      assign digit_bad[gi] = (bcd[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign shifted = work_reg >> 1;

  // After the shift, any BCD nibble >= 8 came from a 10s carry and must lose 3.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
      logic [3:0] nib;
      assign nib = shifted[BIN_W + 4*gi +: 4];
      assign corrected[BIN_W + 4*gi +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
    end
  endgenerate

  assign corrected[BIN_W-1:0] = shifted[BIN_W-1:0];
  assign last_iter = (cnt_reg == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      bin_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      bin_reg   <= bin_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
    bin_next   = bin_reg;
    done_next  = 1'b0;
    err_next   = err_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          if (|digit_bad) begin
            done_next = 1'b1;
            err_next  = 1'b1;
            bin_next  = '0;
          end else begin
            work_next  = {bcd, {BIN_W{1'b0}}};
            cnt_next   = '0;
            err_next   = 1'b0;
            state_next = CONV;
          end
        end
      end
      CONV: begin
        work_next = corrected;
        cnt_next  = cnt_reg + CNT_W'(1);
        if (last_iter) begin
          bin_next   = corrected[BIN_W-1:0];
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bin  = bin_reg;
  assign busy = (state_reg == CONV);
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    logic [15:0] src;
  } exp_t;

  exp_t sb[$];

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) check("busy_done_overlap", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("bin[%h]", e.src), int'(bin), int'(e.bin));
          check($sformatf("err[%h]", e.src), int'(err), int'(e.err));
          $display("txn bcd=%h bin=%0d err=%0b", e.src, bin, err);
        end
      end
    end
  end

  // Drive start for one edge from the current time; returns #1 after that edge.
  task automatic issue(input logic [15:0] v, input int eb, input logic ee, input bit push);
    exp_t e;
    if (push) begin
      e.bin = 14'(eb);
      e.err = ee;
      e.src = v;
      sb.push_back(e);
    end
    bcd   = v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded); also counts busy-high samples.
  task automatic wait_done(output int lat, output int busy_cnt, output int done_cyc);
    lat = 0;
    busy_cnt = 0;
    done_cyc = -1;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1 lat++;
    end
    if (!done) check("done_timeout", 0, 1);
    else done_cyc = cyc;
  endtask

  task automatic run_one(input logic [15:0] v, input int eb, input logic ee,
                         input int exp_lat, input int exp_busy);
    int lat, bc, dc;
    issue(v, eb, ee, 1'b1);
    wait_done(lat, bc, dc);
    check($sformatf("latency[%h]", v), lat, exp_lat);
    check($sformatf("busy_cycles[%h]", v), bc, exp_busy);
  endtask

  initial begin
    int lat, bc, d0, d1, d2;
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = 16'h0;
    #3;
    check("rst_bin", int'(bin), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic conversion.
    run_one(16'h4567, 4567, 1'b0, 14, 14);

    // Back-to-back: each start issued in its predecessor's done cycle.
    @(negedge clk);
    issue(16'h0078, 78, 1'b0, 1'b1);
    wait_done(lat, bc, d0);
    issue(16'h0067, 67, 1'b0, 1'b1);
    wait_done(lat, bc, d1);
    issue(16'h4227, 4227, 1'b0, 1'b1);
    wait_done(lat, bc, d2);
    check("spacing_1", d1 - d0, 15);
    check("spacing_2", d2 - d1, 15);

    // Boundaries.
    @(negedge clk);
    run_one(16'h0000, 0, 1'b0, 14, 14);
    @(negedge clk);
    run_one(16'h9999, 9999, 1'b0, 14, 14);
    @(negedge clk);
    run_one(16'h0009, 9, 1'b0, 14, 14);

    // Invalid digit: immediate error completion, busy never set.
    @(negedge clk);
    run_one(16'h12A4, 0, 1'b1, 0, 0);
    @(negedge clk);
    check("err_held", int'(err), 1);
    check("err_bin_held", int'(bin), 0);
    run_one(16'h0001, 1, 1'b0, 14, 14);

    // Start while busy is ignored; original operand completes on schedule.
    @(negedge clk);
    issue(16'h0123, 123, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("bin_stable_in_conv", int'(bin), 1);
    issue(16'h0456, 456, 1'b0, 1'b0);
    wait_done(lat, bc, d0);
    check("latency_ignored_start", lat, 9);
    repeat (20) begin
      @(posedge clk);
      #1 if (done) check("extra_done", 1, 0);
    end

    // Asynchronous reset during iteration 7 aborts with no done.
    @(negedge clk);
    issue(16'h4567, 4567, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_bin", int'(bin), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) check("done_after_abort", 1, 0);
    end
    @(negedge clk);
    run_one(16'h4567, 4567, 1'b0, 14, 14);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential packed-BCD to binary converter, the inverse of the team's combinational binary-to-BCD block (14-bit binary, 4-digit BCD).
- Uses reverse double-dabble: one shift-and-correct iteration per clock, with a start/busy/done handshake.
- Used where keypad or display-side BCD values must return to binary for arithmetic.
- Also serves as a round-trip checker for the binary-to-BCD block.

Parameters:
DIGITS, 4, number of BCD digits; bcd width = 4*DIGITS.
BIN_W, 14, binary result width and iteration count; must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request conversion; sampled only when idle.
bcd  input  4*DIGITS  packed BCD operand; digit 0 in bits [3:0].
bin  output  BIN_W  registered binary result.
busy  output  1  conversion in progress.
done  output  1  one-cycle completion pulse.
err  output  1  last request had an invalid digit (>9); valid while done=1, then held.

Behaviour:
- Reset:
  - Asynchronous on rst_n low.
  - Clears bin=0, busy=0, done=0, err=0, iteration counter=0 and the working register; state IDLE.
  - Reset mid-conversion aborts the conversion and produces no done pulse.
- States: IDLE, CONV. done is a registered pulse, not a state.
- IDLE, start=1 at edge N:
  - Digits are checked combinationally.
  - If any nibble > 9: stay IDLE, done=1 and err=1 after edge N, bin<=0 (latency 1).
  - Else: load work={bcd, BIN_W'b0}, counter<=0, state<=CONV, busy=1 after edge N, err<=0.
- CONV, each edge:
  - Shift work right by one; the BCD LSB enters the binary MSB.
  - Then every 4-bit BCD nibble >= 8 has 3 subtracted.
  - counter increments.
- Completion:
  - The edge performing iteration BIN_W (edge N+BIN_W, i.e. N+14 by default) loads bin<= binary part of work, done<=1 and busy<=0, and returns to IDLE.
  - Latency from accepting edge to done high: 14 cycles default.
  - Throughput: one conversion per 15 cycles.
- done is high for exactly one cycle.
- Since the state is already IDLE during the done cycle, start in that cycle is accepted (back-to-back).
- start while busy=1 is ignored; the bcd input is not re-sampled during CONV.
- bin and err hold their values until the next completion (valid or error). bin does not change during CONV.
- Arithmetic:
  - Unsigned throughout.
  - The BCD field is all zero after BIN_W iterations for any valid input.
  - Maximum result 10^DIGITS-1 = 9999 (0x270F).
- busy and done are never high together.

Test Plan:
- Reset, then start with bcd=16'h4567 -> busy=1 for 14 cycles, then done pulse with bin=14'd4567 (0x11D7), err=0.
- Sequential requests 16'h0078, 16'h0067, 16'h4227 issued back-to-back, each on its predecessor's done cycle -> bin = 78, 67, 4227; done spacing exactly 15 cycles.
- Boundaries: bcd=16'h0000 -> bin=0; bcd=16'h9999 -> bin=9999; bcd=16'h0009 -> bin=9. All err=0.
- bcd=16'h12A4 -> done one cycle after start with err=1, bin=0, busy never asserted; next valid request 16'h0001 -> err=0, bin=1.
- start pulsed again mid-conversion with a different bcd -> ignored; original result delivered on schedule; single done pulse.
- rst_n low at iteration 7 of 16'h4567 -> all outputs 0 immediately (asynchronous); no done follows. A new start after release converts correctly.
